// File: rtl/char_blitter_if.sv
// Bus bundle for char_blitter: command channel, character-ROM read port, vram write port, status.
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready handshake on the command channel; ROM and vram ports are free-running.
//
// Signals:
//   cmd_valid/cmd_ready       command handshake (transfer when both high at posedge)
//   cmd_char/col/row/fg/bg    glyph code, cell position and colours
//   cmd_transparent           suppress writes of glyph 0-bits
//   crom_adr/crom_q           character ROM address out, data back one cycle later
//   vram_wadr/vram_d/vram_we  framebuffer write port, one pixel per cycle
//   done/err                  end-of-command pulse, err qualifies done
// Modports: master = command issuer / ROM owner / vram owner, slave = the blitter.
interface char_blitter_if #(
  parameter int DW  = 24,
  parameter int AW  = 16,
  parameter int CAW = 11
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [7:0]     cmd_char;
  logic [7:0]     cmd_col;
  logic [7:0]     cmd_row;
  logic [DW-1:0]  cmd_fg;
  logic [DW-1:0]  cmd_bg;
  logic           cmd_transparent;
  logic [CAW-1:0] crom_adr;
  logic [7:0]     crom_q;
  logic [AW-1:0]  vram_wadr;
  logic [DW-1:0]  vram_d;
  logic           vram_we;
  logic           done;
  logic           err;

  modport master (
    output cmd_valid, cmd_char, cmd_col, cmd_row, cmd_fg, cmd_bg, cmd_transparent, crom_q,
    input  cmd_ready, crom_adr, vram_wadr, vram_d, vram_we, done, err
  );

  modport slave (
    input  cmd_valid, cmd_char, cmd_col, cmd_row, cmd_fg, cmd_bg, cmd_transparent, crom_q,
    output cmd_ready, crom_adr, vram_wadr, vram_d, vram_we, done, err
  );
endinterface

// File: rtl/char_blitter.sv
// Text-mode glyph renderer: fetches 8 font rows from the character ROM and writes 64 RGB pixels to vram.
// Latency: first write 3 cycles after accept, row r writes at 10r+3..10r+10, done at cycle 81 (reject: cycle 1).
// Backpressure: cmd_ready only when idle or in the done cycle; cmd_valid while busy is ignored, no queueing.
//
// Ports:
//   CLOCK_50  system clock, all logic on posedge
//   rst_n     asynchronous active-low reset; abandons any command in flight
//   bus       char_blitter_if.slave: command channel, crom_adr/crom_q, vram_wadr/vram_d/vram_we, done/err
module char_blitter #(
  parameter int FB_WIDTH  = 256,
  parameter int FB_HEIGHT = 256,
  parameter int DW        = 24,
  parameter int AW        = 16,
  parameter int CAW       = 11
) (
  input  logic           CLOCK_50,
  input  logic           rst_n,
  char_blitter_if.slave  bus
);

  // FB_WIDTH is a power of two, so the row stride is a shift.
  localparam int         XW    = $clog2(FB_WIDTH);
  localparam logic [8:0] NCOLS = 9'(FB_WIDTH / 8);
  localparam logic [8:0] NROWS = 9'(FB_HEIGHT / 8);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    DRAW  = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     char_q, char_d;
  logic [7:0]     col_q, col_d;
  logic [7:0]     row_q, row_d;
  logic [DW-1:0]  fg_q, fg_d;
  logic [DW-1:0]  bg_q, bg_d;
  logic           transp_q, transp_d;
  logic           err_q, err_d;
  logic [2:0]     gr_q, gr_d;
  logic [2:0]     px_q, px_d;
  logic [7:0]     sr_q, sr_d;
  logic [CAW-1:0] crom_adr_q, crom_adr_d;
  logic [AW-1:0]  vram_wadr_q, vram_wadr_d;
  logic [DW-1:0]  vram_d_q, vram_d_d;
  logic           vram_we_q, vram_we_d;

  logic           accept;
  logic           out_of_range;

  // Pixel address (row*8+gr)*FB_WIDTH + col*8 + px, formed in AW+8 bits and truncated.
  // {row, gr} and {col, px} are exactly row*8+gr and col*8+px.
  function automatic logic [AW-1:0] pix_addr(input logic [7:0] row, input logic [2:0] gr,
                                             input logic [7:0] col, input logic [2:0] px);
    logic [AW+7:0] y;
    logic [AW+7:0] x;
    logic [AW+7:0] a;
    y = (AW+8)'({row, gr});
    x = (AW+8)'({col, px});
    a = (y << XW) + x;
    return a[AW-1:0];
  endfunction

  // FIN doubles as a ready cycle so a held cmd_valid is taken right after done.
  assign accept       = bus.cmd_valid && ((state_q == IDLE) || (state_q == FIN));
  assign out_of_range = ({1'b0, bus.cmd_col} >= NCOLS) || ({1'b0, bus.cmd_row} >= NROWS);

  always_comb begin
    state_d     = state_q;
    char_d      = char_q;
    col_d       = col_q;
    row_d       = row_q;
    fg_d        = fg_q;
    bg_d        = bg_q;
    transp_d    = transp_q;
    err_d       = err_q;
    gr_d        = gr_q;
    px_d        = px_q;
    sr_d        = sr_q;
    crom_adr_d  = crom_adr_q;
    vram_wadr_d = vram_wadr_q;
    vram_d_d    = vram_d_q;
    vram_we_d   = 1'b0;

    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (accept) begin
          char_d   = bus.cmd_char;
          col_d    = bus.cmd_col;
          row_d    = bus.cmd_row;
          fg_d     = bus.cmd_fg;
          bg_d     = bus.cmd_bg;
          transp_d = bus.cmd_transparent;
          gr_d     = 3'd0;
          if (out_of_range) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            err_d   = 1'b0;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        // ROM data for this row is on crom_q now; bit 7 becomes the first pixel.
        sr_d    = bus.crom_q;
        px_d    = 3'd0;
        state_d = DRAW;
      end
      DRAW: begin
        sr_d = {sr_q[6:0], 1'b0};
        px_d = px_q + 3'd1;
        if (px_q == 3'd7) begin
          if (gr_q == 3'd7) begin
            state_d = FIN;
          end else begin
            gr_d    = gr_q + 3'd1;
            state_d = FETCH;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output registers are loaded from the next-state view so that each
    // FETCH/DRAW cycle carries its own address/pixel on the registered ports.
    if (state_d == FETCH) begin
      crom_adr_d = CAW'({char_d, gr_d});
    end
    if (state_d == DRAW) begin
      vram_wadr_d = pix_addr(row_q, gr_q, col_q, px_d);
      vram_d_d    = sr_d[7] ? fg_q : bg_q;
      vram_we_d   = sr_d[7] | ~transp_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      char_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
      transp_q    <= 1'b0;
      err_q       <= 1'b0;
      gr_q        <= '0;
      px_q        <= '0;
      sr_q        <= '0;
      crom_adr_q  <= '0;
      vram_wadr_q <= '0;
      vram_d_q    <= '0;
      vram_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      char_q      <= char_d;
      col_q       <= col_d;
      row_q       <= row_d;
      fg_q        <= fg_d;
      bg_q        <= bg_d;
      transp_q    <= transp_d;
      err_q       <= err_d;
      gr_q        <= gr_d;
      px_q        <= px_d;
      sr_q        <= sr_d;
      crom_adr_q  <= crom_adr_d;
      vram_wadr_q <= vram_wadr_d;
      vram_d_q    <= vram_d_d;
      vram_we_q   <= vram_we_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) || (state_q == FIN);
  assign bus.crom_adr  = crom_adr_q;
  assign bus.vram_wadr = vram_wadr_q;
  assign bus.vram_d    = vram_d_q;
  assign bus.vram_we   = vram_we_q;
  assign bus.done      = (state_q == FIN);
  assign bus.err       = (state_q == FIN) && err_q;

endmodule

// File: tb/tb_char_blitter.sv
// Self-checking bench for char_blitter: scoreboard of expected ROM reads and vram writes.
// Latency: n/a.
// Backpressure: commands offered with cmd_valid and held until accepted.
module tb_char_blitter;
  localparam int DW  = 24;
  localparam int AW  = 16;
  localparam int CAW = 11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  char_blitter_if #(.DW(DW), .AW(AW), .CAW(CAW)) bus ();

  char_blitter #(.FB_WIDTH(256), .FB_HEIGHT(256), .DW(DW), .AW(AW), .CAW(CAW)) dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  // Character ROM model, 1-cycle synchronous read.
  logic [7:0] rom [0:2047];
  always @(posedge clk) bus.crom_q <= rom[bus.crom_adr];

  typedef struct { int tag; logic [AW-1:0] adr; logic [DW-1:0] dat; int cyc; } wexp_t;
  typedef struct { int tag; logic [CAW-1:0] adr; int cyc; } cexp_t;

  wexp_t wq[$];
  cexp_t cq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int acc_n = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  logic [AW-1:0] last_wadr = '0;

  // Edge counter and accept tracker: cycle n of a command is the period after accept edge + n - 1.
  always @(posedge clk) begin
    if (rst_n && bus.cmd_valid && bus.cmd_ready) begin
      acc_cyc <= cyc;
      acc_n   <= acc_n + 1;
    end
    cyc <= cyc + 1;
  end

  // Output monitor, sampled on the falling edge.
  initial begin : mon
    wexp_t w;
    cexp_t c;
    int rel;
    forever begin
      @(negedge clk);
      rel = cyc - acc_cyc;
      if (rst_n && bus.done) done_cnt++;
      if (rst_n && bus.vram_we) begin
        wr_cnt++;
        last_wadr = bus.vram_wadr;
        n_cmp++;
        if (wq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got wadr=%h d=%h cycle=%0d, required no write", bus.vram_wadr, bus.vram_d, rel);
        end else begin
          w = wq.pop_front();
          if (w.tag != acc_n || bus.vram_wadr !== w.adr || bus.vram_d !== w.dat || rel != w.cyc) begin
            n_bad++;
            $display("FAIL vram_write: got cmd%0d wadr=%h d=%h cycle=%0d, required cmd%0d wadr=%h d=%h cycle=%0d",
                     acc_n, bus.vram_wadr, bus.vram_d, rel, w.tag, w.adr, w.dat, w.cyc);
          end
        end
      end
      if (cq.size() > 0) begin
        if (cq[0].tag == acc_n && rel == cq[0].cyc) begin
          c = cq.pop_front();
          n_cmp++;
          if (bus.crom_adr !== c.adr) begin
            n_bad++;
            $display("FAIL crom_adr: got %h cycle=%0d, required %h", bus.crom_adr, rel, c.adr);
          end
        end
      end
    end
  end

  // Expected ROM reads and vram writes for one accepted command.
  task automatic push_cmd(input int tag, input logic [7:0] ch, col, row,
                          input logic [DW-1:0] fg, bg, input logic tr);
    logic [7:0] b;
    logic [31:0] a;
    cexp_t c;
    wexp_t w;
    for (int r = 0; r < 8; r++) begin
      c.tag = tag; c.adr = {ch, 3'(r)}; c.cyc = 10 * r + 1;
      cq.push_back(c);
      b = rom[{ch, 3'(r)}];
      for (int p = 0; p < 8; p++) begin
        if (b[7-p] || !tr) begin
          a = 32'((int'(row) * 8 + r) * 256 + int'(col) * 8 + p);
          w.tag = tag; w.adr = a[AW-1:0]; w.dat = b[7-p] ? fg : bg; w.cyc = 10 * r + 3 + p;
          wq.push_back(w);
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] ch, col, row, input logic [DW-1:0] fg, bg,
                      input logic tr, input bit hold);
    int n0;
    bit ok;
    n0 = acc_n;
    ok = 1'b0;
    bus.cmd_char = ch; bus.cmd_col = col; bus.cmd_row = row;
    bus.cmd_fg = fg; bus.cmd_bg = bg; bus.cmd_transparent = tr;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (acc_n != n0) begin ok = 1'b1; break; end
    end
    if (!hold) bus.cmd_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no accept in 300 cycles, required accept of char %h", ch);
    end
  endtask

  task automatic wait_done(output int rel, output logic e);
    rel = -1;
    e = 1'bx;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done) begin rel = cyc - acc_cyc; e = bus.err; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_char = '0; bus.cmd_col = '0; bus.cmd_row = '0;
    bus.cmd_fg = '0; bus.cmd_bg = '0; bus.cmd_transparent = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 7;
    if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %b, required 1", bus.cmd_ready); end
    if (bus.crom_adr !== '0) begin n_bad++; $display("FAIL rst_crom_adr: got %h, required 0", bus.crom_adr); end
    if (bus.vram_wadr !== '0) begin n_bad++; $display("FAIL rst_vram_wadr: got %h, required 0", bus.vram_wadr); end
    if (bus.vram_d !== '0) begin n_bad++; $display("FAIL rst_vram_d: got %h, required 0", bus.vram_d); end
    if (bus.vram_we !== 1'b0) begin n_bad++; $display("FAIL rst_vram_we: got %b, required 0", bus.vram_we); end
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b, required 0", bus.done); end
    if (bus.err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b, required 0", bus.err); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.cmd_ready !== 1'b1 || bus.vram_we !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got ready=%b we=%b done=%b, required 1 0 0", bus.cmd_ready, bus.vram_we, bus.done);
    end
  endtask

  task automatic test_opaque();
    int rel;
    logic e;
    push_cmd(acc_n + 1, 8'h54, 8'd1, 8'd2, 24'hFFFFFF, 24'h000000, 1'b0);
    send(8'h54, 8'd1, 8'd2, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0);
    wait_done(rel, e);
    n_cmp += 4;
    if (rel != 81) begin n_bad++; $display("FAIL opaque_done_cycle: got %0d, required 81", rel); end
    if (e !== 1'b0) begin n_bad++; $display("FAIL opaque_err: got %b, required 0", e); end
    if (last_wadr !== 16'h170F) begin n_bad++; $display("FAIL opaque_last_wadr: got %h, required 170f", last_wadr); end
    if (wq.size() != 0 || cq.size() != 0) begin
      n_bad++; $display("FAIL opaque_missing: got %0d writes %0d reads left, required 0 0", wq.size(), cq.size());
      wq.delete(); cq.delete();
    end
  endtask

  task automatic test_transparent();
    int rel, pc, w0, n0;
    logic e;
    pc = 0;
    for (int r = 0; r < 8; r++) pc += $countones(rom[{8'h49, 3'(r)}]);
    w0 = wr_cnt;
    push_cmd(acc_n + 1, 8'h49, 8'd0, 8'd0, 24'h12AB34, 24'h00FF00, 1'b1);
    send(8'h49, 8'd0, 8'd0, 24'h12AB34, 24'h00FF00, 1'b1, 1'b0);
    n0 = acc_n;
    // Commands offered while busy must be dropped.
    for (int k = 0; k < 3; k++) begin
      repeat (5) @(negedge clk);
      bus.cmd_char = 8'h4D; bus.cmd_col = 8'd3; bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
    wait_done(rel, e);
    n_cmp += 5;
    if (rel != 81) begin n_bad++; $display("FAIL transp_done_cycle: got %0d, required 81", rel); end
    if (e !== 1'b0) begin n_bad++; $display("FAIL transp_err: got %b, required 0", e); end
    if (wr_cnt - w0 != pc) begin n_bad++; $display("FAIL transp_write_count: got %0d, required %0d", wr_cnt - w0, pc); end
    if (acc_n != n0) begin n_bad++; $display("FAIL busy_accept: got %0d accepts, required 0", acc_n - n0); end
    if (wq.size() != 0 || cq.size() != 0) begin
      n_bad++; $display("FAIL transp_missing: got %0d writes %0d reads left, required 0 0", wq.size(), cq.size());
      wq.delete(); cq.delete();
    end
  endtask

  task automatic test_out_of_range();
    int rel, w0;
    logic e;
    logic [CAW-1:0] c0;
    c0 = bus.crom_adr;
    w0 = wr_cnt;
    send(8'h41, 8'd32, 8'd0, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0);
    wait_done(rel, e);
    n_cmp += 2;
    if (rel != 1) begin n_bad++; $display("FAIL oor_col_done_cycle: got %0d, required 1", rel); end
    if (e !== 1'b1) begin n_bad++; $display("FAIL oor_col_err: got %b, required 1", e); end
    send(8'h42, 8'd0, 8'd32, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0);
    wait_done(rel, e);
    repeat (5) @(negedge clk);
    n_cmp += 4;
    if (rel != 1) begin n_bad++; $display("FAIL oor_row_done_cycle: got %0d, required 1", rel); end
    if (e !== 1'b1) begin n_bad++; $display("FAIL oor_row_err: got %b, required 1", e); end
    if (wr_cnt != w0) begin n_bad++; $display("FAIL oor_writes: got %0d, required 0", wr_cnt - w0); end
    if (bus.crom_adr !== c0) begin n_bad++; $display("FAIL oor_crom_adr: got %h, required %h", bus.crom_adr, c0); end
  endtask

  task automatic test_back_to_back();
    int rel, a0, d0;
    logic e;
    d0 = done_cnt;
    push_cmd(acc_n + 1, 8'h49, 8'd4, 8'd5, 24'hA0B0C0, 24'h010203, 1'b0);
    push_cmd(acc_n + 2, 8'h4D, 8'd6, 8'd5, 24'h0F0F0F, 24'h707070, 1'b0);
    send(8'h49, 8'd4, 8'd5, 24'hA0B0C0, 24'h010203, 1'b0, 1'b1);
    a0 = acc_cyc;
    send(8'h4D, 8'd6, 8'd5, 24'h0F0F0F, 24'h707070, 1'b0, 1'b0);
    n_cmp++;
    if (acc_cyc - a0 != 81) begin n_bad++; $display("FAIL b2b_second_accept: got cycle %0d, required 81", acc_cyc - a0); end
    wait_done(rel, e);
    n_cmp += 4;
    if (rel != 81) begin n_bad++; $display("FAIL b2b_done_cycle: got %0d, required 81", rel); end
    if (e !== 1'b0) begin n_bad++; $display("FAIL b2b_err: got %b, required 0", e); end
    if (done_cnt - d0 != 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d, required 2", done_cnt - d0); end
    if (wq.size() != 0 || cq.size() != 0) begin
      n_bad++; $display("FAIL b2b_missing: got %0d writes %0d reads left, required 0 0", wq.size(), cq.size());
      wq.delete(); cq.delete();
    end
  endtask

  task automatic test_bottom_right();
    int rel;
    logic e;
    push_cmd(acc_n + 1, 8'h54, 8'd31, 8'd31, 24'h336699, 24'hCCBBAA, 1'b0);
    send(8'h54, 8'd31, 8'd31, 24'h336699, 24'hCCBBAA, 1'b0, 1'b0);
    wait_done(rel, e);
    n_cmp += 3;
    if (rel != 81 || e !== 1'b0) begin n_bad++; $display("FAIL br_done: got cycle %0d err %b, required 81 0", rel, e); end
    if (last_wadr !== 16'hFFFF) begin n_bad++; $display("FAIL br_last_wadr: got %h, required ffff", last_wadr); end
    if (wq.size() != 0 || cq.size() != 0) begin
      n_bad++; $display("FAIL br_missing: got %0d writes %0d reads left, required 0 0", wq.size(), cq.size());
      wq.delete(); cq.delete();
    end
  endtask

  task automatic test_reset_mid();
    int rel, d0;
    logic e;
    bit hit;
    d0 = done_cnt;
    hit = 1'b0;
    push_cmd(acc_n + 1, 8'h41, 8'd2, 8'd3, 24'h445566, 24'h778899, 1'b0);
    send(8'h41, 8'd2, 8'd3, 24'h445566, 24'h778899, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (cyc - acc_cyc == 40) begin hit = 1'b1; break; end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    wq.delete(); cq.delete();
    #1;
    n_cmp += 4;
    if (!hit) begin n_bad++; $display("FAIL rmid_reach_cycle40: got timeout, required cycle 40"); end
    if (bus.vram_we !== 1'b0) begin n_bad++; $display("FAIL rmid_vram_we: got %b, required 0", bus.vram_we); end
    if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_cmd_ready: got %b, required 1", bus.cmd_ready); end
    if (bus.crom_adr !== '0) begin n_bad++; $display("FAIL rmid_crom_adr: got %h, required 0", bus.crom_adr); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    n_cmp++;
    if (done_cnt != d0) begin n_bad++; $display("FAIL rmid_no_done: got %0d pulses, required 0", done_cnt - d0); end
    push_cmd(acc_n + 1, 8'h54, 8'd5, 8'd7, 24'hFFFFFF, 24'h000000, 1'b0);
    send(8'h54, 8'd5, 8'd7, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0);
    wait_done(rel, e);
    n_cmp += 2;
    if (rel != 81 || e !== 1'b0) begin n_bad++; $display("FAIL rmid_fresh_done: got cycle %0d err %b, required 81 0", rel, e); end
    if (wq.size() != 0 || cq.size() != 0) begin
      n_bad++; $display("FAIL rmid_missing: got %0d writes %0d reads left, required 0 0", wq.size(), cq.size());
      wq.delete(); cq.delete();
    end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) rom[a] = 8'((a * 37 + 11) ^ (a >> 2));
    // 'T' for 0x54, and 0x49 row 0 with only the outer pixels lit.
    rom[11'h2A0] = 8'hFF; rom[11'h2A1] = 8'hFF; rom[11'h2A2] = 8'h18; rom[11'h2A3] = 8'h18;
    rom[11'h2A4] = 8'h18; rom[11'h2A5] = 8'h18; rom[11'h2A6] = 8'h18; rom[11'h2A7] = 8'h00;
    rom[11'h248] = 8'h81;
    test_reset();
    test_opaque();
    test_transparent();
    test_out_of_range();
    test_back_to_back();
    test_bottom_right();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
